// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the programmable sequence generator.
// Holds the FSM state encoding, the run-mode codes and the length-legality check.
// No ports; imported by seq_gen_cfg and seq_gen_prog.
package seq_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // A pattern length is usable when it is 1..max inclusive.
    function automatic logic len_ok(input int unsigned len, input int unsigned max);
        return (len != 0) && (len <= max);
    endfunction

endpackage

// File: rtl/seq_gen_cfg.sv
// Config store for seq_gen_prog: pattern/length/mode registers, legality check and accept/reject.
// Ports: clk/rst; idle (from FSM); cfg_valid/cfg_ready handshake with cfg_seq/cfg_len/cfg_mode;
//        cfg_err (registered reject pulse), cfg_reject (same-cycle reject), seq/len/mode (effective config).
module seq_gen_cfg
    import seq_gen_pkg::*;
#(
    parameter int                 MAX_LEN     = 16,
    parameter logic [MAX_LEN-1:0] DEFAULT_SEQ = MAX_LEN'(16'h0027),
    parameter int                 DEFAULT_LEN = 6,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               idle,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_seq,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_mode,
    output logic               cfg_err,
    output logic               cfg_reject,
    output logic [MAX_LEN-1:0] seq,
    output logic [LEN_W-1:0]   len,
    output logic               mode
);

    logic [MAX_LEN-1:0] seq_r;
    logic [LEN_W-1:0]   len_r;
    logic               mode_r;
    logic               take;
    logic               legal;

    assign cfg_ready  = idle;
    assign take       = cfg_valid & idle;
    assign legal      = len_ok(32'(cfg_len), 32'(MAX_LEN));
    assign cfg_reject = take & ~legal;

    // A legal request in the same cycle as start must drive that run, so the
    // incoming config bypasses the registers while it is being accepted.
    assign seq  = (take & legal) ? cfg_seq  : seq_r;
    assign len  = (take & legal) ? cfg_len  : len_r;
    assign mode = (take & legal) ? cfg_mode : mode_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            seq_r   <= DEFAULT_SEQ;
            len_r   <= LEN_W'(DEFAULT_LEN);
            mode_r  <= MODE_CONT;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= take & ~legal;
            if (take & legal) begin
                seq_r  <= cfg_seq;
                len_r  <= cfg_len;
                mode_r <= cfg_mode;
            end
        end
    end

endmodule

// File: rtl/seq_gen_prog.sv
// Programmable serial sequence generator: emits a loaded 1..MAX_LEN-bit pattern MSB first, cyclic or one-shot.
// Ports: clk/rst; cfg_valid/cfg_ready + cfg_seq/cfg_len/cfg_mode; start/stop/en controls;
//        q/q_valid/idx/busy registered, done/cfg_ready combinational, cfg_err one-cycle reject pulse.
module seq_gen_prog
    import seq_gen_pkg::*;
#(
    parameter int                 MAX_LEN     = 16,
    parameter logic [MAX_LEN-1:0] DEFAULT_SEQ = MAX_LEN'(16'h0027),
    parameter int                 DEFAULT_LEN = 6,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_seq,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_mode,
    input  logic               start,
    input  logic               stop,
    input  logic               en,
    output logic               q,
    output logic               q_valid,
    output logic [LEN_W-1:0]   idx,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    state_t             state;
    logic [MAX_LEN-1:0] seq;
    logic [LEN_W-1:0]   len;
    logic               mode;
    logic               cfg_reject;
    logic               idle;
    logic               last;
    logic               launch;
    logic [LEN_W-1:0]   first_sel;
    logic [LEN_W-1:0]   next_sel;
    logic [MAX_LEN-1:0] first_sh;
    logic [MAX_LEN-1:0] next_sh;
    logic               first_bit;
    logic               next_bit;

    seq_gen_cfg #(
        .MAX_LEN     (MAX_LEN),
        .DEFAULT_SEQ (DEFAULT_SEQ),
        .DEFAULT_LEN (DEFAULT_LEN)
    ) u_cfg (
        .clk        (clk),
        .rst        (rst),
        .idle       (idle),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_seq    (cfg_seq),
        .cfg_len    (cfg_len),
        .cfg_mode   (cfg_mode),
        .cfg_err    (cfg_err),
        .cfg_reject (cfg_reject),
        .seq        (seq),
        .len        (len),
        .mode       (mode)
    );

    assign idle   = (state == ST_IDLE);
    assign last   = (idx == len - LEN_W'(1));
    // A start arriving with a rejected config is dropped.
    assign launch = start & ~cfg_reject;
    assign done   = busy & en & last & ~stop;

    // Bit selection by shifting rather than indexing keeps every select in range;
    // next_sel wraps when idx is the last position but is unused in that case.
    assign first_sel = len - LEN_W'(1);
    assign next_sel  = len - LEN_W'(2) - idx;
    assign first_sh  = seq >> first_sel;
    assign next_sh   = seq >> next_sel;
    assign first_bit = first_sh[0];
    assign next_bit  = next_sh[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            q       <= 1'b0;
            q_valid <= 1'b0;
            idx     <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state   <= ST_RUN;
                        q       <= first_bit;
                        q_valid <= 1'b1;
                        idx     <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state   <= ST_IDLE;
                        q       <= 1'b0;
                        q_valid <= 1'b0;
                        idx     <= '0;
                        busy    <= 1'b0;
                    end else if (en) begin
                        if (last) begin
                            if (mode == MODE_ONESHOT) begin
                                state   <= ST_IDLE;
                                q       <= 1'b0;
                                q_valid <= 1'b0;
                                idx     <= '0;
                                busy    <= 1'b0;
                            end else begin
                                q   <= first_bit;
                                idx <= '0;
                            end
                        end else begin
                            q   <= next_bit;
                            idx <= idx + LEN_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    q       <= 1'b0;
                    q_valid <= 1'b0;
                    idx     <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_prog.sv
// Testbench for seq_gen_prog: directed scenarios plus randomized traffic against a pattern-list model.
// Each cycle the driver pushes the expected observation; a monitor pops and compares at the falling edge.
// Ports: none.
module tb_seq_gen_prog;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_seq;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_mode;
    logic               start;
    logic               stop;
    logic               en;
    logic               q;
    logic               q_valid;
    logic [LEN_W-1:0]   idx;
    logic               busy;
    logic               done;
    logic               cfg_err;

    always #5 clk = ~clk;

    seq_gen_prog dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_seq   (cfg_seq),
        .cfg_len   (cfg_len),
        .cfg_mode  (cfg_mode),
        .start     (start),
        .stop      (stop),
        .en        (en),
        .q         (q),
        .q_valid   (q_valid),
        .idx       (idx),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    typedef struct packed {
        logic             q;
        logic             q_valid;
        logic [LEN_W-1:0] idx;
        logic             busy;
        logic             done;
        logic             cfg_err;
        logic             cfg_ready;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: the pattern is a list of bits in emission order and the
    // generator is a pointer walking that list.
    bit pat[$];
    bit m_run;
    bit m_oneshot;
    bit m_err;
    int m_pos;

    task automatic load_pat(input logic [15:0] s, input int len);
        pat.delete();
        for (int k = 0; k < len; k++) pat.push_back(s[len-1-k]);
    endtask

    task automatic model_reset();
        load_pat(16'h0027, 6);
        m_run     = 1'b0;
        m_oneshot = 1'b0;
        m_err     = 1'b0;
        m_pos     = 0;
    endtask

    task automatic cyc(input bit r, input bit cv, input logic [15:0] s, input logic [4:0] l,
                       input bit md, input bit st, input bit sp, input bit e);
        obs_t x;
        bit   legal;
        @(posedge clk);
        #1;
        rst = r; cfg_valid = cv; cfg_seq = s; cfg_len = l; cfg_mode = md;
        start = st; stop = sp; en = e;
        x.q         = m_run ? pat[m_pos] : 1'b0;
        x.q_valid   = m_run;
        x.idx       = m_run ? 5'(m_pos) : 5'd0;
        x.busy      = m_run;
        x.done      = m_run && e && (m_pos == pat.size() - 1) && !sp;
        x.cfg_err   = m_err;
        x.cfg_ready = !m_run;
        exp_q.push_back(x);
        if (!r) begin
            model_reset();
        end else if (!m_run) begin
            legal = (l >= 1) && (l <= MAX_LEN);
            m_err = cv && !legal;
            if (cv && legal) begin
                load_pat(s, int'(l));
                m_oneshot = md;
            end
            if (st && !(cv && !legal)) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else begin
            m_err = 1'b0;
            if (sp) begin
                m_run = 1'b0;
                m_pos = 0;
            end else if (e) begin
                if (m_pos == pat.size() - 1) begin
                    m_pos = 0;
                    if (m_oneshot) m_run = 1'b0;
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    task automatic run_en(input bit e);
        cyc(1, 0, 16'h0, 5'd0, 0, 0, 0, e);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) run_en(0);
    endtask

    // Monitor: compares every expected observation against the live outputs.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.q = q; a.q_valid = q_valid; a.idx = idx; a.busy = busy;
                a.done = done; a.cfg_err = cfg_err; a.cfg_ready = cfg_ready;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL obs%0d t=%0t got q=%b qv=%b idx=%0d busy=%b done=%b err=%b rdy=%b exp q=%b qv=%b idx=%0d busy=%b done=%b err=%b rdy=%b",
                             vectors, $time, a.q, a.q_valid, a.idx, a.busy, a.done, a.cfg_err, a.cfg_ready,
                             e.q, e.q_valid, e.idx, e.busy, e.done, e.cfg_err, e.cfg_ready);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; cfg_valid = 1'b0; cfg_seq = '0; cfg_len = '0; cfg_mode = 1'b0;
        start = 1'b0; stop = 1'b0; en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Default pattern, continuous, en held high.
        cyc(1, 0, 16'h0, 5'd0, 0, 1, 0, 1);
        for (int i = 0; i < 14; i++) run_en(1);

        // Stop at idx 3 with en high, then restart.
        cyc(1, 0, 16'h0, 5'd0, 0, 0, 1, 0);
        cyc(1, 0, 16'h0, 5'd0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) run_en(1);
        cyc(1, 0, 16'h0, 5'd0, 0, 0, 1, 1);
        cyc(1, 0, 16'h0, 5'd0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) run_en(1);

        // Gapped enable 1,0,0,1.
        for (int i = 0; i < 16; i++) run_en((i % 4 == 0) || (i % 4 == 3));
        cyc(1, 0, 16'h0, 5'd0, 0, 0, 1, 0);

        // Illegal lengths, a start carrying an illegal config, then cfg_valid while running.
        cyc(1, 1, 16'hFFFF, 5'd0, 1, 0, 0, 0);
        cyc(1, 1, 16'hFFFF, 5'd17, 1, 0, 0, 0);
        cyc(1, 1, 16'hFFFF, 5'd20, 1, 1, 0, 1);
        idle_n(1);
        cyc(1, 0, 16'h0, 5'd0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) run_en(1);
        cyc(1, 1, 16'hFFFF, 5'd0, 1, 0, 0, 1);
        cyc(1, 1, 16'h0005, 5'd3, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) run_en(1);
        cyc(1, 0, 16'h0, 5'd0, 0, 0, 1, 1);

        // One-shot 1011.
        cyc(1, 1, 16'h000B, 5'd4, 1, 0, 0, 0);
        cyc(1, 0, 16'h0, 5'd0, 0, 1, 0, 1);
        for (int i = 0; i < 6; i++) run_en(1);
        idle_n(1);

        // Length 1, continuous, loaded together with start; then reset mid-run.
        cyc(1, 1, 16'h0001, 5'd1, 0, 1, 0, 1);
        for (int i = 0; i < 6; i++) run_en(i != 2);
        cyc(0, 0, 16'h0, 5'd0, 0, 0, 0, 1);
        idle_n(1);
        cyc(1, 0, 16'h0, 5'd0, 0, 1, 0, 1);
        for (int i = 0; i < 8; i++) run_en(1);

        // Maximum length pattern.
        cyc(1, 0, 16'h0, 5'd0, 0, 0, 1, 0);
        cyc(1, 1, 16'hA5C3, 5'd16, 0, 1, 0, 1);
        for (int i = 0; i < 20; i++) run_en(1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          r, cv, md, st, sp, e;
            logic [15:0] s;
            logic [4:0]  l;
            r  = ($urandom_range(0, 299) != 0);
            cv = ($urandom_range(0, 3) == 0);
            s  = 16'($urandom);
            l  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 16));
            md = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 9) < 7);
            cyc(r, cv, s, l, md, st, sp, e);
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_gen_prog.md
Name: seq_gen_prog

Overview:
Programmable serial sequence generator, the parametrised successor to the team's fixed-pattern shift-register and counter generators. Emits a runtime-loaded pattern of 1..MAX_LEN bits, MSB first. Supports continuous (cyclic) or one-shot mode, start/stop control and a per-bit advance enable. Sits beside the sequence detectors as a stimulus/pattern source; its reset default reproduces the 6-bit 100111 generator.

Parameters:
MAX_LEN, 16, maximum pattern length in bits (>=2)
LEN_W, $clog2(MAX_LEN+1), width of length/index fields (derived, not overridden)
DEFAULT_SEQ, 16'h0027, pattern after reset (right-aligned; bits [5:0] = 100111)
DEFAULT_LEN, 6, pattern length after reset

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
cfg_valid  in  1  config load request
cfg_ready  out  1  high in IDLE only; config accepted when cfg_valid & cfg_ready
cfg_seq  in  MAX_LEN  pattern, right-aligned; bit cfg_len-1 is emitted first
cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN
cfg_mode  in  1  0 = continuous, 1 = one-shot
start  in  1  begin emission (honoured in IDLE only)
stop  in  1  abort emission (honoured in RUN only)
en  in  1  advance to next bit when high in RUN
q  out  1  current sequence bit
q_valid  out  1  q is a live sequence bit
idx  out  LEN_W  position of current bit, 0 = first
busy  out  1  high in RUN
done  out  1  last bit being consumed
cfg_err  out  1  one-cycle pulse: illegal cfg_len rejected

Behaviour:
- Reset (rst=0 at edge): seq=DEFAULT_SEQ, len=DEFAULT_LEN, mode=continuous, state IDLE; q=0, q_valid=0, idx=0, busy=0, cfg_err=0; cfg_ready=1.
- FSM: IDLE, RUN. All outputs except done and cfg_ready are registered.
- Config: accepted only in IDLE. cfg_len==0 or >MAX_LEN -> stored config unchanged, cfg_err=1 next cycle. Legal -> seq/len/mode updated at that edge. cfg_valid in RUN is ignored (no err).
- IDLE + start: next cycle RUN, busy=1, q_valid=1, idx=0, q=seq[len-1]. Latency start->first bit = 1 cycle.
- start with legal cfg_valid in same cycle: new config is used for the run (bypass). Start with rejected config: start ignored, stays IDLE, cfg_err=1.
- RUN, en=1, idx<len-1: idx+1, q=seq[len-2-idx]. en=0: all outputs hold.
- done = busy & en & (idx==len-1) & ~stop; combinational, high exactly one cycle per pass.
- RUN, en=1, idx==len-1: continuous -> idx=0, q=seq[len-1], stay RUN; one-shot -> IDLE, q=0, q_valid=0, busy=0, idx=0.
- stop in RUN: priority over en; next cycle IDLE, q=0, q_valid=0, idx=0; no done that cycle.
- start in RUN ignored; stop in IDLE ignored.
- len=1: each en cycle is a last bit; continuous gives constant q with done every en cycle.
- Reset mid-run: immediate return to reset state; loaded config lost (defaults restored).
- idx compare and bit select use LEN_W-bit unsigned arithmetic; no out-of-range indexing of seq.

Decomposition:
- Package seq_gen_pkg: state enum {ST_IDLE, ST_RUN}, MODE_CONT=1'b0, MODE_ONESHOT=1'b1, length-legality function len_ok(len, max).
- One sub-module: seq_gen_cfg. Holds the config registers, legality check, cfg_ready/cfg_err and the bypass mux. The top holds the FSM and output datapath.

Test Plan:
- Reset, start=1 one cycle, en=1 held -> q from cycle after start: 1,0,0,1,1,1,1,0,0,... continuous; done high on every 6th bit; idx 0..5 wrapping.
- Load cfg_seq=16'h000B, cfg_len=4, cfg_mode=1, then start, en=1 -> q=1,0,1,1, done on 4th bit; next cycle q_valid=0, busy=0, cfg_ready=1.
- Run default pattern, en pattern 1,0,0,1 -> q/idx hold during en=0 cycles; no bit skipped or duplicated.
- Assert stop at idx=3 with en=1 -> next cycle q_valid=0, idx=0, busy=0, no done pulse; restart begins at q=1, idx=0.
- cfg_len=0 and cfg_len=MAX_LEN+1 in IDLE -> cfg_err pulse, config unchanged (restart yields 100111); cfg_valid during RUN -> ignored, no err.
- cfg_len=1, cfg_seq[0]=1, continuous -> q constantly 1, done every en cycle; rst=0 mid-run -> next cycle all outputs at reset values, default config restored.
